// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants.
// Holds the forward and inverse S-box tables (FIPS-197), the byte width
// and lookup helpers used by the substitution lanes.
package aes_pkg;

  localparam int ByteW = 8;

  typedef logic [ByteW-1:0] sbox_byte_t;

  // Mode tag carried with every word through the pipeline.
  typedef enum logic {
    ModeFwd = 1'b0,
    ModeInv = 1'b1
  } sbox_mode_e;

  localparam sbox_byte_t SboxFwd [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam sbox_byte_t SboxInv [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic sbox_byte_t sbox_fwd(input sbox_byte_t b);
    return SboxFwd[b];
  endfunction

  function automatic sbox_byte_t sbox_inv(input sbox_byte_t b);
    return SboxInv[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte AES substitution, purely combinational.
// Ports:
//   in_byte_i  - byte to substitute
//   inv_i      - 0 = forward S-box, 1 = inverse S-box
//   out_byte_o - substituted byte
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [ByteW-1:0] in_byte_i,
  input  logic             inv_i,
  output logic [ByteW-1:0] out_byte_o
);

  always_comb begin
    out_byte_o = (inv_i == ModeInv) ? sbox_inv(in_byte_i) : sbox_fwd(in_byte_i);
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane AES S-box with a valid/ready pipeline of STAGES register stages.
// The table lookup happens combinationally in front of stage 0; later stages
// only carry data, mode tag and valid bit. Each stage advances when it is
// empty or the stage after it advances, so a stall backs up word by word.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake; in_data lanes, in_inv mode tag
//   out_valid/out_ready - output handshake; out_data lanes, out_inv mode tag
//   flush               - drop every in-flight word at the next edge
//   busy                - some stage holds a valid word
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ByteW*LANES-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ByteW*LANES-1:0] out_data,
  output logic                   out_inv,
  input  logic                   flush,
  output logic                   busy
);

  localparam int Last = STAGES - 1;

  typedef logic [ByteW*LANES-1:0] word_t;

  word_t             sub_data;
  word_t             data_q [STAGES];
  word_t             data_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] inv_q, inv_d;
  logic [STAGES-1:0] adv;
  logic              in_fire;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .in_byte_i  (in_data[ByteW*i +: ByteW]),
      .inv_i      (in_inv),
      .out_byte_o (sub_data[ByteW*i +: ByteW])
    );
  end

  // Stage k can move when the consumer is taking a word or any stage from k
  // downward is empty; written in closed form to avoid a ripple chain.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) begin
          adv[k] = 1'b1;
        end
      end
    end
  end

  // rst_n gates in_ready so nothing is offered as accepted while in reset.
  assign in_ready = rst_n & ~flush & adv[0];
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    inv_d   = inv_q;
    data_d  = data_q;

    if (adv[0]) begin
      valid_d[0] = in_fire;
      if (in_fire) begin
        data_d[0] = sub_data;
        inv_d[0]  = in_inv;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        // Only move payload with a real word so idle stages do not toggle.
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          inv_d[k]  = inv_q[k-1];
        end
      end
    end

    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      inv_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      inv_q   <= inv_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[Last];
  assign out_data  = data_q[Last];
  assign out_inv   = inv_q[Last];
  assign busy      = |valid_q;

endmodule
